// File: rtl/mp_add_sequencer.sv
// rtl/mp_add_sequencer.sv - multi-precision adder, one WORD_W lookahead slice per cycle (optional MPA_SUB_EN subtract)
module mp_add_sequencer #(
    parameter int WORD_W    = 4,
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] op_a,
    input  logic [WORD_W*NUM_WORDS-1:0] op_b,
    input  logic                        carry_in,
`ifdef MPA_SUB_EN
    input  logic                        op_sub,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] result,
    output logic                        carry_out,
    output logic                        busy
);

    localparam int N     = WORD_W * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [N-1:0]      a_reg;
    logic [N-1:0]      b_reg;
    logic              creg;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       base;
    logic              last_slice;

    logic [WORD_W-1:0] a_slice;
    logic [WORD_W-1:0] b_slice;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W:0]   carry;
    logic [WORD_W-1:0] slice_sum;
    logic              slice_cout;
    logic              term;
    logic              pp;

    assign base       = 32'(idx) * WORD_W;
    assign last_slice = (idx == IDX_W'(NUM_WORDS - 1));
    assign a_slice    = WORD_W'(a_reg >> base);
    assign b_slice    = WORD_W'(b_reg >> base);

    // Each carry is a flat sum of generate terms gated by the propagate run
    // below it, so no carry waits on the one beneath it.
    always_comb begin
        g        = a_slice & b_slice;
        p        = a_slice ^ b_slice;
        carry    = '0;
        carry[0] = creg;
        term     = 1'b0;
        pp       = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            carry[i+1] = term | (pp & creg);
        end
        slice_sum  = p ^ carry[WORD_W-1:0];
        slice_cout = carry[WORD_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            creg      <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        idx   <= '0;
`ifdef MPA_SUB_EN
                        // Subtract as A + ~B + 1: invert once here, seed the carry.
                        b_reg <= op_sub ? ~op_b : op_b;
                        creg  <= op_sub ? 1'b1 : carry_in;
`else
                        b_reg <= op_b;
                        creg  <= carry_in;
`endif
                    end
                end
                S_RUN: begin
                    result <= (result & ~(N'({WORD_W{1'b1}}) << base))
                            | (N'(slice_sum) << base);
                    creg   <= slice_cout;
                    if (last_slice) begin
                        carry_out <= slice_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb/tb_mp_add_sequencer.sv - randomized and directed bench for mp_add_sequencer
module tb_mp_add_sequencer;

    localparam int WW = 4;
    localparam int NW = 4;
    localparam int N  = WW * NW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         carry_in;
`ifdef MPA_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    mp_add_sequencer #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
`ifdef MPA_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    endfunction

    // Reference: a job occupies NW edges of compute, then waits for out_ready.
    logic         m_busy, m_done, m_c, pend_c, sub_now;
    int           m_cnt, m_jobs, dut_jobs, cyc;
    logic [N-1:0] m_res, pend_r;

    always_comb begin
`ifdef MPA_SUB_EN
        sub_now = op_sub;
`else
        sub_now = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_res = '0; m_c = 1'b0;
        end else begin
            cyc++;
            if (out_valid && out_ready) dut_jobs++;
            if (!m_busy) begin
                if (in_valid) begin
                    {pend_c, pend_r} = ref_sum(op_a, op_b, carry_in, sub_now);
                    m_busy = 1'b1;
                    m_cnt  = NW;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1; m_res = pend_r; m_c = pend_c;
                end
            end else if (out_ready) begin
                m_busy = 1'b0; m_done = 1'b0; m_jobs++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_result", 32'(result), 32'd0);
            chk("rst_carry", 32'(carry_out), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_done));
            if (!m_busy || m_done) begin
                chk("result", 32'(result), 32'(m_res));
                chk("carry_out", 32'(carry_out), 32'(m_c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        int n;
        n = 0;
        op_a = a; op_b = b; carry_in = cin; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) chk("out_timeout", 32'(lat), 32'd0);
    endtask

    task automatic expect_job(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic cin, input logic [N-1:0] er, input logic ec);
        int lat;
        send(a, b, cin);
        wait_out(lat);
        chk({name, "_lat"}, 32'(lat), NW);
        chk({name, "_res"}, 32'(result), 32'(er));
        chk({name, "_cout"}, 32'(carry_out), 32'(ec));
        tick();
    endtask

    int acc_prev, acc_now, n;
    logic [N-1:0] held;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; carry_in = 1'b0;
`ifdef MPA_SUB_EN
        op_sub = 1'b0;
`endif
        cyc = 0; m_jobs = 0; dut_jobs = 0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        chk("model_pin_basic", 32'(ref_sum(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h05555);
        chk("model_pin_ripple", 32'(ref_sum(16'hFFFF, 16'h0000, 1'b1, 1'b0)), 32'h10000);
        chk("model_pin_sub", 32'(ref_sum(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);

        expect_job("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        expect_job("ripple0", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        expect_job("ripple1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Backpressure: result holds and new operands wait.
        out_ready = 1'b0;
        send(16'h0A0A, 16'h0101, 1'b0);
        wait_out(n);
        held = result;
        chk("bp_res", 32'(held), 32'h0B0B);
        op_a = 16'h1111; op_b = 16'h2222; carry_in = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'(result), 32'(held));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_out(n);
        chk("bp_next_res", 32'(result), 32'h3333);
        tick();

        // Reset in RUN with idx = 2.
        send(16'h5678, 16'h1111, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_res", 32'(result), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        expect_job("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        acc_prev = -1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            op_a = N'($urandom); op_b = N'($urandom); carry_in = 1'($urandom);
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            acc_now = cyc + 1;
            if (acc_prev >= 0) chk("b2b_period", 32'(acc_now - acc_prev), 32'd6);
            acc_prev = acc_now;
            tick();
            op_a = N'($urandom); op_b = N'($urandom);
        end
        in_valid = 1'b0;
        repeat (8) tick();

`ifdef MPA_SUB_EN
        op_sub = 1'b1;
        expect_job("sub_pos", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        expect_job("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        op_sub = 1'b0;
`endif

        // Random traffic; unaccepted operands churn every cycle.
        repeat (400) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            op_a = N'($urandom); op_b = N'($urandom); carry_in = 1'($urandom);
`ifdef MPA_SUB_EN
            op_sub = 1'($urandom);
`endif
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();
        chk("job_count", 32'(dut_jobs), 32'(m_jobs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
